// File: rtl/pipe_hazard_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller:
// forward-select encoding, controller FSM states and flush bit positions.
package pipe_hazard_pkg;

    // EX operand source select
    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    // Hazard controller states
    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_LSTALL = 2'b01,
        ST_SBWAIT = 2'b10
    } hz_state_e;

    // Bit positions inside the flush vector (youngest stage first)
    localparam int FLUSH_IFID_BIT  = 0;
    localparam int FLUSH_IDEX_BIT  = 1;
    localparam int FLUSH_EXMEM_BIT = 2;

    // EX/MEM result is newer than MEM/WB, so it wins when both match
    function automatic fwd_sel_e fwd_select(input logic exmem_hit, input logic memwb_hit);
        fwd_sel_e sel;
        if (exmem_hit) begin
            sel = FWD_EXMEM;
        end else if (memwb_hit) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_mdu_scoreboard.sv
// Register scoreboard and latency counter for the multi-cycle MDU.
// One operation is tracked at a time; its destination bit stays set until
// the result is ready, and the done pulse is decoded from the counter state.
module mdu_scoreboard
    import pipe_hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] look_a,
    input  logic [REG_AW-1:0] look_b,
    output logic              busy,
    output logic              done,
    output logic              hit_a,
    output logic              hit_b
);

    localparam int                NREG     = 2 ** REG_AW;
    localparam logic [3:0]        CNT_INIT = 4'(MDU_LAT - 1);
    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

    logic [NREG-1:0]   sb_r;
    logic [NREG-1:0]   sb_nxt_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_nxt_s;
    logic              busy_r;
    logic              busy_nxt_s;
    logic [REG_AW-1:0] rd_r;
    logic [REG_AW-1:0] rd_nxt_s;
    logic              done_s;

    assign done_s = busy_r && (cnt_r == 4'd0);

    // Next scoreboard/counter state: retire the in-flight op, then apply a new issue
    always_comb begin
        sb_nxt_s   = sb_r;
        cnt_nxt_s  = cnt_r;
        busy_nxt_s = busy_r;
        rd_nxt_s   = rd_r;

        // Drop the tracked bit when the op completes or is replaced
        if (busy_r && (done_s || issue)) begin
            sb_nxt_s[rd_r] = 1'b0;
        end else begin
            sb_nxt_s = sb_r;
        end

        // A new issue overrides completion so a same-register reissue keeps its bit
        if (issue) begin
            busy_nxt_s         = 1'b1;
            cnt_nxt_s          = CNT_INIT;
            rd_nxt_s           = issue_rd;
            sb_nxt_s[issue_rd] = (issue_rd != REG_ZERO);
        end else if (done_s) begin
            busy_nxt_s = 1'b0;
            cnt_nxt_s  = 4'd0;
        end else if (busy_r) begin
            cnt_nxt_s = cnt_r - 4'd1;
        end else begin
            cnt_nxt_s = 4'd0;
        end
    end

    // Scoreboard state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb_r   <= {NREG{1'b0}};
            cnt_r  <= 4'd0;
            busy_r <= 1'b0;
            rd_r   <= REG_ZERO;
        end else begin
            sb_r   <= sb_nxt_s;
            cnt_r  <= cnt_nxt_s;
            busy_r <= busy_nxt_s;
            rd_r   <= rd_nxt_s;
        end
    end

    assign busy  = busy_r;
    assign done  = done_s;
    assign hit_a = sb_r[look_a] && (look_a != REG_ZERO);
    assign hit_b = sb_r[look_b] && (look_b != REG_ZERO);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline.
// Handles EX operand forwarding, multi-cycle load-use stalls, MDU scoreboard
// stalls and taken-branch flushes. Optional statistics counters are built
// when HAZ_STATS_EN is defined.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int LOAD_LAT    = 1,
    parameter int MDU_LAT     = 4,
    parameter int FLUSH_DEPTH = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [REG_AW-1:0]      i_ifid_rs,
    input  logic [REG_AW-1:0]      i_ifid_rt,
    input  logic                   i_ifid_is_mdu,
    input  logic [REG_AW-1:0]      i_idex_rs,
    input  logic [REG_AW-1:0]      i_idex_rt,
    input  logic                   i_idex_memread,
    input  logic                   i_mdu_issue,
    input  logic [REG_AW-1:0]      i_mdu_rd,
    input  logic [REG_AW-1:0]      i_exmem_rd,
    input  logic                   i_exmem_regwr,
    input  logic [REG_AW-1:0]      i_memwb_rd,
    input  logic                   i_memwb_regwr,
    input  logic                   i_br_taken,
    output logic                   o_pc_write,
    output logic                   o_ifid_write,
    output logic                   o_idex_bubble,
    output logic [FLUSH_DEPTH-1:0] o_flush,
    output logic [1:0]             o_fwd_a,
    output logic [1:0]             o_fwd_b,
    output logic                   o_mdu_busy,
    output logic                   o_mdu_done
`ifdef HAZ_STATS_EN
   ,output logic [31:0]            o_stall_cnt,
    output logic [31:0]            o_flush_cnt
`endif
);

    localparam logic [REG_AW-1:0] REG_ZERO  = {REG_AW{1'b0}};
    // Remaining stall cycles after the entry cycle, which already stalls
    localparam logic [2:0]        LOAD_INIT = 3'(LOAD_LAT - 1);

    hz_state_e  state_r;
    hz_state_e  state_nxt_s;
    logic [2:0] lcnt_r;
    logic [2:0] lcnt_nxt_s;
    logic       stall_s;
    logic       load_haz_s;
    logic       sb_haz_s;
    logic       sb_hit_a_s;
    logic       sb_hit_b_s;
    logic       mdu_busy_s;
    logic       mdu_done_s;
    logic       mdu_issue_s;
    logic       ex_hit_a_s;
    logic       ex_hit_b_s;
    logic       wb_hit_a_s;
    logic       wb_hit_b_s;

    // An MDU op in EX during a taken branch is younger than the branch
    assign mdu_issue_s = i_mdu_issue && !i_br_taken;

    mdu_scoreboard #(
        .REG_AW  (REG_AW),
        .MDU_LAT (MDU_LAT)
    ) u_sb (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .issue    (mdu_issue_s),
        .issue_rd (i_mdu_rd),
        .look_a   (i_ifid_rs),
        .look_b   (i_ifid_rt),
        .busy     (mdu_busy_s),
        .done     (mdu_done_s),
        .hit_a    (sb_hit_a_s),
        .hit_b    (sb_hit_b_s)
    );

    // Forwarding matches; r0 is hardwired and never forwarded
    assign ex_hit_a_s = i_exmem_regwr && (i_exmem_rd != REG_ZERO) && (i_exmem_rd == i_idex_rs);
    assign ex_hit_b_s = i_exmem_regwr && (i_exmem_rd != REG_ZERO) && (i_exmem_rd == i_idex_rt);
    assign wb_hit_a_s = i_memwb_regwr && (i_memwb_rd != REG_ZERO) && (i_memwb_rd == i_idex_rs);
    assign wb_hit_b_s = i_memwb_regwr && (i_memwb_rd != REG_ZERO) && (i_memwb_rd == i_idex_rt);

    assign o_fwd_a = fwd_select(ex_hit_a_s, wb_hit_a_s);
    assign o_fwd_b = fwd_select(ex_hit_b_s, wb_hit_b_s);

    // Hazard conditions seen by the instruction in IF/ID
    assign load_haz_s = i_idex_memread && (i_idex_rt != REG_ZERO) &&
                        ((i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt));
    assign sb_haz_s   = sb_hit_a_s || sb_hit_b_s || (i_ifid_is_mdu && mdu_busy_s);

    // Next-state and stall decode; a taken branch overrides any stall
    always_comb begin
        state_nxt_s = state_r;
        lcnt_nxt_s  = lcnt_r;
        stall_s     = 1'b0;
        if (i_br_taken) begin
            state_nxt_s = ST_RUN;
            lcnt_nxt_s  = 3'd0;
            stall_s     = 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (load_haz_s) begin
                        stall_s = 1'b1;
                        if (LOAD_INIT != 3'd0) begin
                            state_nxt_s = ST_LSTALL;
                            lcnt_nxt_s  = LOAD_INIT;
                        end else begin
                            state_nxt_s = ST_RUN;
                            lcnt_nxt_s  = 3'd0;
                        end
                    end else if (sb_haz_s) begin
                        stall_s     = 1'b1;
                        state_nxt_s = ST_SBWAIT;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_LSTALL: begin
                    stall_s = 1'b1;
                    if (lcnt_r <= 3'd1) begin
                        state_nxt_s = ST_RUN;
                        lcnt_nxt_s  = 3'd0;
                    end else begin
                        lcnt_nxt_s = lcnt_r - 3'd1;
                    end
                end
                ST_SBWAIT: begin
                    stall_s = 1'b1;
                    // The done pulse clears the blocking bit at this edge
                    if (!sb_haz_s || mdu_done_s) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_SBWAIT;
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                    lcnt_nxt_s  = 3'd0;
                end
            endcase
        end
    end

    // FSM state and load-latency counter registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= ST_RUN;
            lcnt_r  <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            lcnt_r  <= lcnt_nxt_s;
        end
    end

    assign o_pc_write    = !stall_s;
    assign o_ifid_write  = !stall_s;
    assign o_idex_bubble = stall_s;
    assign o_flush       = {FLUSH_DEPTH{i_br_taken}};
    assign o_mdu_busy    = mdu_busy_s;
    assign o_mdu_done    = mdu_done_s;

`ifdef HAZ_STATS_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Saturating stall-cycle and taken-branch counters
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (i_br_taken && (flush_cnt_r != 32'hFFFF_FFFF)) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign o_stall_cnt = stall_cnt_r;
    assign o_flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (LOAD_LAT=2, MDU_LAT=4).
module tb_pipe_hazard_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [4:0] i_ifid_rs, i_ifid_rt, i_idex_rs, i_idex_rt;
    logic       i_ifid_is_mdu, i_idex_memread, i_mdu_issue;
    logic [4:0] i_mdu_rd, i_exmem_rd, i_memwb_rd;
    logic       i_exmem_regwr, i_memwb_regwr, i_br_taken;
    logic       o_pc_write, o_ifid_write, o_idex_bubble, o_mdu_busy, o_mdu_done;
    logic [2:0] o_flush;
    logic [1:0] o_fwd_a, o_fwd_b;

    int n_vec = 0;
    int n_err = 0;

    pipe_hazard_ctrl #(
        .REG_AW(5), .LOAD_LAT(2), .MDU_LAT(4), .FLUSH_DEPTH(3)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_ifid_rs(i_ifid_rs), .i_ifid_rt(i_ifid_rt), .i_ifid_is_mdu(i_ifid_is_mdu),
        .i_idex_rs(i_idex_rs), .i_idex_rt(i_idex_rt), .i_idex_memread(i_idex_memread),
        .i_mdu_issue(i_mdu_issue), .i_mdu_rd(i_mdu_rd),
        .i_exmem_rd(i_exmem_rd), .i_exmem_regwr(i_exmem_regwr),
        .i_memwb_rd(i_memwb_rd), .i_memwb_regwr(i_memwb_regwr),
        .i_br_taken(i_br_taken),
        .o_pc_write(o_pc_write), .o_ifid_write(o_ifid_write), .o_idex_bubble(o_idex_bubble),
        .o_flush(o_flush), .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b),
        .o_mdu_busy(o_mdu_busy), .o_mdu_done(o_mdu_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [4:0] ifid_rs;
        logic [4:0] ifid_rt;
        logic       ifid_is_mdu;
        logic [4:0] idex_rs;
        logic [4:0] idex_rt;
        logic       idex_memread;
        logic [4:0] exmem_rd;
        logic       exmem_regwr;
        logic [4:0] memwb_rd;
        logic       memwb_regwr;
        logic       br;
        logic       exp_stall;
        logic [2:0] exp_flush;
        logic [1:0] exp_fa;
        logic [1:0] exp_fb;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    logic [11:0] obs;
    assign obs = {o_pc_write, o_ifid_write, o_idex_bubble, o_flush,
                  o_fwd_a, o_fwd_b, o_mdu_busy, o_mdu_done};

    function automatic logic [11:0] expb(input logic stall, input logic [2:0] fl,
                                         input logic [1:0] fa, input logic [1:0] fb,
                                         input logic busy, input logic done);
        return {~stall, ~stall, stall, fl, fa, fb, busy, done};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %03h expected %03h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_ifid_rs = 5'd0; i_ifid_rt = 5'd0; i_ifid_is_mdu = 1'b0;
        i_idex_rs = 5'd0; i_idex_rt = 5'd0; i_idex_memread = 1'b0;
        i_mdu_issue = 1'b0; i_mdu_rd = 5'd0;
        i_exmem_rd = 5'd0; i_exmem_regwr = 1'b0;
        i_memwb_rd = 5'd0; i_memwb_regwr = 1'b0;
        i_br_taken = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
    endtask

    task automatic apply(input vec_t v);
        i_ifid_rs = v.ifid_rs; i_ifid_rt = v.ifid_rt; i_ifid_is_mdu = v.ifid_is_mdu;
        i_idex_rs = v.idex_rs; i_idex_rt = v.idex_rt; i_idex_memread = v.idex_memread;
        i_exmem_rd = v.exmem_rd; i_exmem_regwr = v.exmem_regwr;
        i_memwb_rd = v.memwb_rd; i_memwb_regwr = v.memwb_regwr;
        i_br_taken = v.br;
        i_mdu_issue = 1'b0; i_mdu_rd = 5'd0;
    endtask

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        // ifid_rs ifid_rt mdu idex_rs idex_rt mrd exmem wr memwb wr br | stall flush fa fb
        vecs[0]  = '{5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00};
        vecs[1]  = '{5'd0, 5'd0, 1'b0, 5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b10, 2'b00};
        vecs[2]  = '{5'd0, 5'd0, 1'b0, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000, 2'b01, 2'b00};
        vecs[3]  = '{5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00};
        vecs[4]  = '{5'd0, 5'd0, 1'b0, 5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000, 2'b10, 2'b00};
        vecs[5]  = '{5'd0, 5'd0, 1'b0, 5'd3, 5'd0, 1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00};
        vecs[6]  = '{5'd0, 5'd0, 1'b0, 5'd4, 5'd7, 1'b0, 5'd4, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 3'b000, 2'b10, 2'b01};
        vecs[7]  = '{5'd0, 5'd0, 1'b0, 5'd9, 5'd9, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b10, 2'b10};
        vecs[8]  = '{5'd2, 5'd0, 1'b0, 5'd0, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 3'b000, 2'b00, 2'b00};
        vecs[9]  = '{5'd1, 5'd2, 1'b0, 5'd0, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 3'b000, 2'b00, 2'b00};
        vecs[10] = '{5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00};
        vecs[11] = '{5'd3, 5'd4, 1'b0, 5'd0, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00};
        vecs[12] = '{5'd2, 5'd0, 1'b0, 5'd0, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00};
        vecs[13] = '{5'd2, 5'd0, 1'b0, 5'd0, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 3'b111, 2'b00, 2'b00};
        vecs[14] = '{5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00};
        vecs[15] = '{5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00};

        clear_inputs();
        i_rst_n = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b1;

        // Reset state
        @(negedge i_clk);
        check("reset", obs, expb(1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));
        tick();

        // Single-cycle table: forwarding and hazard detection from RUN
        for (int i = 0; i < NV; i++) begin
            apply(vecs[i]);
            @(negedge i_clk);
            check($sformatf("vec%0d", i), obs,
                  expb(vecs[i].exp_stall, vecs[i].exp_flush, vecs[i].exp_fa, vecs[i].exp_fb, 1'b0, 1'b0));
            tick();
            do_reset();
        end

        // Load-use with LOAD_LAT=2: two stall cycles, then run
        i_idex_memread = 1'b1; i_idex_rt = 5'd2; i_ifid_rs = 5'd2;
        @(negedge i_clk);
        check("load_c0", obs, expb(1'b1, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));
        tick();
        i_idex_memread = 1'b0;
        @(negedge i_clk);
        check("load_c1", obs, expb(1'b1, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));
        tick();
        @(negedge i_clk);
        check("load_c2", obs, expb(1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));
        tick();
        @(negedge i_clk);
        check("load_c3", obs, expb(1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));
        tick();
        do_reset();

        // Branch in LSTALL: flush wins, pc_write stays high
        i_idex_memread = 1'b1; i_idex_rt = 5'd2; i_ifid_rs = 5'd2;
        tick();
        i_idex_memread = 1'b0; i_br_taken = 1'b1;
        @(negedge i_clk);
        check("br_lstall", obs, expb(1'b0, 3'b111, 2'b00, 2'b00, 1'b0, 1'b0));
        tick();
        i_br_taken = 1'b0;
        @(negedge i_clk);
        check("br_lstall_after", obs, expb(1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));
        tick();
        do_reset();

        // Branch on the load-hazard entry cycle: no LSTALL follows
        i_idex_memread = 1'b1; i_idex_rt = 5'd2; i_ifid_rs = 5'd2; i_br_taken = 1'b1;
        tick();
        i_idex_memread = 1'b0; i_br_taken = 1'b0;
        @(negedge i_clk);
        check("br_entry_run", obs, expb(1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));
        tick();
        do_reset();

        // MDU rd=r5, consumer stalls until the done pulse in cycle 4
        i_mdu_issue = 1'b1; i_mdu_rd = 5'd5;
        @(negedge i_clk);
        check("mdu_c0", obs, expb(1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));
        tick();
        i_mdu_issue = 1'b0; i_ifid_rs = 5'd5;
        for (int c = 1; c <= 5; c++) begin
            @(negedge i_clk);
            check($sformatf("mdu_c%0d", c), obs,
                  expb((c <= 4), 3'b000, 2'b00, 2'b00, (c <= 4), (c == 4)));
            tick();
        end
        do_reset();

        // Branch while waiting on the scoreboard: older MDU op keeps running
        i_mdu_issue = 1'b1; i_mdu_rd = 5'd5;
        tick();
        i_mdu_issue = 1'b0; i_ifid_rs = 5'd5;
        tick();
        i_br_taken = 1'b1;
        @(negedge i_clk);
        check("br_sbwait", obs, expb(1'b0, 3'b111, 2'b00, 2'b00, 1'b1, 1'b0));
        tick();
        i_br_taken = 1'b0; i_ifid_rs = 5'd0;
        @(negedge i_clk);
        check("br_sbwait_c3", obs, expb(1'b0, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0));
        tick();
        @(negedge i_clk);
        check("br_sbwait_done", obs, expb(1'b0, 3'b000, 2'b00, 2'b00, 1'b1, 1'b1));
        tick();
        do_reset();

        // Taken branch with MDU issue in the same cycle: issue dropped
        i_br_taken = 1'b1; i_mdu_issue = 1'b1; i_mdu_rd = 5'd6;
        @(negedge i_clk);
        check("br_issue_c0", obs, expb(1'b0, 3'b111, 2'b00, 2'b00, 1'b0, 1'b0));
        tick();
        i_br_taken = 1'b0; i_mdu_issue = 1'b0; i_ifid_rs = 5'd6;
        @(negedge i_clk);
        check("br_issue_c1", obs, expb(1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));
        tick();
        do_reset();

        // Reissue to r5 on the done cycle keeps the bit; is_mdu while busy stalls
        i_mdu_issue = 1'b1; i_mdu_rd = 5'd5;
        tick();
        i_mdu_issue = 1'b0;
        tick();
        tick();
        tick();
        i_mdu_issue = 1'b1;
        @(negedge i_clk);
        check("reissue_done", obs, expb(1'b0, 3'b000, 2'b00, 2'b00, 1'b1, 1'b1));
        tick();
        i_mdu_issue = 1'b0; i_ifid_rs = 5'd5;
        @(negedge i_clk);
        check("reissue_hold", obs, expb(1'b1, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0));
        tick();
        do_reset();
        i_mdu_issue = 1'b1; i_mdu_rd = 5'd7;
        tick();
        i_mdu_issue = 1'b0; i_ifid_is_mdu = 1'b1;
        @(negedge i_clk);
        check("mdu_struct", obs, expb(1'b1, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0));
        tick();
        do_reset();

        // Reset in the middle of an MDU op aborts it without a done pulse
        i_mdu_issue = 1'b1; i_mdu_rd = 5'd5;
        tick();
        i_mdu_issue = 1'b0;
        @(negedge i_clk);
        check("rst_mdu_c1", obs, expb(1'b0, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0));
        tick();
        do_reset();
        i_ifid_rs = 5'd5;
        for (int c = 3; c <= 5; c++) begin
            @(negedge i_clk);
            check($sformatf("rst_mdu_c%0d", c), obs, expb(1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
